// File: rtl/pwm_audio_out_pkg.sv
// Shared definitions for the PWM audio output block.
//   PWM_BITS  : width of the PWM counter and of the duty value
//   MIDSCALE  : silence level of offset-binary samples (ramp target)
//   state_e   : 2-bit FSM encoding, also visible on the state_dbg port
package pwm_audio_out_pkg;

  localparam int PWM_BITS = 8;
  localparam int MIDSCALE = 128;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_audio_out_core.sv
// Free-running PWM counter plus comparator.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   duty     : high time of the current period, in counter ticks
//   pwm_out  : registered (cnt < duty), one clock behind the counter
//   boundary : high in the cycle where the counter holds its last value
module pwm_core #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out,
  output logic                boundary
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;   // wraps naturally at all-ones
    pwm_d = (cnt_q < duty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign boundary = &cnt_q;
  assign pwm_out  = pwm_q;

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output with click-free ramping and a one-deep sample buffer.
//   clk         : system clock
//   rst         : asynchronous active-low reset (forces pwm_out low at once)
//   sample_tick : one-cycle strobe, sample is valid
//   sample      : unsigned offset-binary audio sample
//   enable      : 1 = play, 0 = ramp to silence
//   clear_ovr   : one-cycle strobe clearing overrun
//   pwm_out     : registered PWM pin drive
//   busy        : state is not IDLE
//   overrun     : sticky, a buffered sample was replaced before being used
//   state_dbg   : current FSM state (state_e encoding)
// Handshake: sample_tick is a fire-and-forget valid with no ready; the block
// always accepts the sample into the hold buffer, flagging overrun when an
// unused sample is displaced outside a boundary cycle.
module pwm_audio_out
  import pwm_audio_out_pkg::*;
#(
  parameter int PWM_BITS = pwm_audio_out_pkg::PWM_BITS,
  parameter int MIDSCALE = pwm_audio_out_pkg::MIDSCALE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic [PWM_BITS-1:0] sample,
  input  logic                enable,
  input  logic                clear_ovr,
  output logic                pwm_out,
  output logic                busy,
  output logic                overrun,
  output logic [1:0]          state_dbg
);

  localparam logic [PWM_BITS-1:0] MID_LVL = PWM_BITS'(MIDSCALE);

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic                overrun_q, overrun_d;
  logic                boundary;

  pwm_core #(.PWM_BITS(PWM_BITS)) u_core (
    .clk      (clk),
    .rst      (rst),
    .duty     (duty_q),
    .pwm_out  (pwm_out),
    .boundary (boundary)
  );

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;

    // Every boundary retires the buffered sample (used in RUN, dropped
    // elsewhere), so a tick landing on a boundary is never an overrun.
    overrun_d = (overrun_q & ~clear_ovr) |
                (sample_tick & hold_valid_q & ~boundary);

    if (boundary) begin
      unique case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          if (enable) state_d = ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!enable) begin
            state_d = ST_RAMP_DOWN;
          end else begin
            // Step toward silence level; cannot wrap since MID_LVL lies
            // strictly on the far side of the step direction.
            if (duty_q < MID_LVL)      duty_d = duty_q + 1'b1;
            else if (duty_q > MID_LVL) duty_d = duty_q - 1'b1;
            if (duty_d == MID_LVL) state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable)           state_d = ST_RAMP_DOWN;
          else if (hold_valid_q) duty_d  = hold_q;
        end
        ST_RAMP_DOWN: begin
          if (enable) begin
            state_d = ST_RAMP_UP;
          end else begin
            if (duty_q != '0) duty_d = duty_q - 1'b1;
            if (duty_d == '0) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Hold is read above before being overwritten, so a tick on a RUN
    // boundary moves the old sample to duty and keeps the new one pending.
    if (sample_tick) begin
      hold_d       = sample;
      hold_valid_d = 1'b1;
    end else if (boundary) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      duty_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule
